// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel programmable clock-enable strobes with per-channel divide and phase.
// A reconfiguration realigns every channel and holds locked low for LOCK_DELAY cycles.
module clk_en_gen #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16,
    parameter int DIV_RESET  = 2,
    parameter int LOCK_DELAY = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW        = $clog2(LOCK_DELAY + 1)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              run,
    output logic [NUM_CH-1:0] en_out,
    output logic              locked
);
    typedef enum logic {SETTLE, RUN} state_t;

    localparam logic [CH_W:0]    NCH  = NUM_CH[CH_W:0];
    localparam logic [LW-1:0]    LAST = LW'(LOCK_DELAY - 1);
    localparam logic [LW-1:0]    LMAX = LW'(LOCK_DELAY);
    localparam logic [CNT_W-1:0] DRST = CNT_W'(DIV_RESET);

    state_t             r_state;
    logic [LW-1:0]      r_lcnt;
    logic               r_lock;
    logic               r_pend;
    logic [NUM_CH-1:0]  r_en;
    logic [CNT_W-1:0]   r_div   [NUM_CH];
    logic [CNT_W-1:0]   r_phase [NUM_CH];
    logic [CNT_W-1:0]   r_c     [NUM_CH];

    logic [CNT_W-1:0]   w_div_eff;
    logic [CNT_W-1:0]   w_phase_eff;
    logic               w_acc;
    logic               w_go;
    logic [CNT_W-1:0]   w_cur [NUM_CH];
    logic [CNT_W-1:0]   w_nxt [NUM_CH];
    logic [NUM_CH-1:0]  w_hit;

    assign cfg_ready = r_lock;
    assign locked    = r_lock;
    assign en_out    = r_en;

    // w_cur is the counter value for the cycle being computed: SETTLE presents the phase preload
    always_comb begin
        w_div_eff   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
        w_phase_eff = (cfg_phase >= w_div_eff) ? w_div_eff - 1'b1 : cfg_phase;
        w_acc       = cfg_valid && r_lock && ({1'b0, cfg_ch} < NCH);
        w_go        = (r_state == RUN) || (r_lcnt == LAST);
        for (int i = 0; i < NUM_CH; i++) begin
            w_cur[i] = (r_state == RUN) ? r_c[i] : r_phase[i];
            w_hit[i] = w_cur[i] == r_div[i] - 1'b1;
            w_nxt[i] = w_hit[i] ? '0 : w_cur[i] + 1'b1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= SETTLE;
            r_lcnt  <= '0;
            r_lock  <= 1'b0;
            r_pend  <= 1'b0;
            r_en    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]   <= DRST;
                r_phase[i] <= '0;
                r_c[i]     <= '0;
            end
        end else begin
            r_pend <= w_acc;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_acc && cfg_ch == CH_W'(i)) begin
                    r_div[i]   <= w_div_eff;
                    r_phase[i] <= w_phase_eff;
                end
            end
            if (r_pend) begin
                r_state <= SETTLE;
                r_lcnt  <= '0;
                r_lock  <= 1'b0;
                r_en    <= '0;
            end else begin
                if (r_lcnt != LMAX) r_lcnt <= r_lcnt + 1'b1;
                if (w_go) begin
                    r_state <= RUN;
                    r_lock  <= 1'b1;
                end
                r_en <= {NUM_CH{w_go && run}} & w_hit;
                for (int i = 0; i < NUM_CH; i++) r_c[i] <= (w_go && run) ? w_nxt[i] : w_cur[i];
            end
        end
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed and randomized checks of clk_en_gen against a cycle-level behavioural model.
module tb_clk_en_gen;
    localparam int LD = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [0:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_phase = '0;
    logic       run = 1'b1;
    logic [1:0] en_out;
    logic       locked;

    logic       cfg_valid3 = 1'b0;
    logic       cfg_ready3;
    logic [1:0] cfg_ch3 = '0;
    logic [2:0] en_out3;
    logic       locked3;

    int n_cmp = 0;
    int n_bad = 0;

    clk_en_gen #(.NUM_CH(2), .CNT_W(8), .DIV_RESET(2), .LOCK_DELAY(LD)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .run(run),
        .en_out(en_out), .locked(locked));

    clk_en_gen #(.NUM_CH(3), .CNT_W(8), .DIV_RESET(2), .LOCK_DELAY(LD)) u3 (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch3), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .run(run),
        .en_out(en_out3), .locked(locked3));

    always #5 refclk = ~refclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: run-count k since lock; channel strobes when (k+phase+1) is a multiple of div.
    int   m_div [2];
    int   m_ph  [2];
    bit   m_lock, m_pend;
    int   m_left, m_k;
    logic [1:0] m_en;

    always @(posedge refclk) begin
        bit acc;
        int d;
        logic [1:0] en_n;
        if (rst) begin
            m_div = '{2, 2};
            m_ph = '{0, 0};
            m_lock = 0;
            m_pend = 0;
            m_left = LD;
            m_k = 0;
            m_en = '0;
        end else begin
            acc = cfg_valid && m_lock;
            en_n = '0;
            if (m_pend) begin
                m_lock = 0;
                m_left = LD;
            end else begin
                if (!m_lock) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_lock = 1;
                        m_k = 0;
                    end
                end
                if (m_lock) begin
                    for (int c = 0; c < 2; c++) en_n[c] = run && ((m_k + m_ph[c] + 1) % m_div[c] == 0);
                    if (run) m_k++;
                end
            end
            m_en = en_n;
            if (acc) begin
                d = (cfg_div == 0) ? 1 : int'(cfg_div);
                m_div[cfg_ch] = d;
                m_ph[cfg_ch] = (int'(cfg_phase) >= d) ? d - 1 : int'(cfg_phase);
            end
            m_pend = acc;
        end
        #1;
        chk("model en_out", 32'(en_out), 32'(m_en));
        chk("model locked", 32'(locked), 32'(m_lock));
        chk("model cfg_ready", 32'(cfg_ready), 32'(m_lock));
    end

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic cfg(input int ch, input int dv, input int ph, output int waited);
        logic rdy;
        bit ok = 0;
        cfg_ch = 1'(ch);
        cfg_div = 8'(dv);
        cfg_phase = 8'(ph);
        cfg_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            rdy = cfg_ready;
            tick();
            waited++;
            ok = rdy;
        end
        cfg_valid = 1'b0;
        if (!ok) chk("cfg accept timeout", 0, 1);
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic trace(input int n, output logic [15:0] t0, output logic [15:0] t1);
        t0 = '0;
        t1 = '0;
        for (int j = 0; j < n; j++) begin
            t0[j] = en_out[0];
            t1[j] = en_out[1];
            tick();
        end
    endtask

    initial begin
        int w, n, p3;
        logic [15:0] t0, t1;
        logic lk;
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("locked low in settle", 32'(locked), 0);
            chk("en_out low in settle", 32'(en_out), 0);
        end
        tick();
        chk("locked after edge 4", 32'(locked), 1);
        trace(6, t0, t1);
        chk("reset ch0 k=1,3,5", 32'(t0), 32'h2A);
        chk("reset ch1 k=1,3,5", 32'(t1), 32'h2A);

        cfg(0, 5, 0, w);
        chk("ch0 cfg accepted at once", w, 1);
        chk("locked holds one cycle", 32'(locked), 1);
        tick();
        chk("locked drops", 32'(locked), 0);
        chk("ready drops", 32'(cfg_ready), 0);
        wait_lock(n);
        chk("relock cycles", n, 4);
        trace(15, t0, t1);
        chk("ch0 div5 k=4,9,14", 32'(t0), 32'h4210);
        chk("ch1 realigned", 32'(t1), 32'h2AAA);

        cfg(1, 5, 3, w);
        tick();
        wait_lock(n);
        trace(12, t0, t1);
        chk("ch0 k=4,9", 32'(t0), 32'h210);
        chk("ch1 ph3 k=1,6,11", 32'(t1), 32'h842);

        cfg(0, 0, 0, w);
        tick();
        cfg(1, 5, 7, w);
        chk("held cfg accepted at first ready", w, 5);
        tick();
        wait_lock(n);
        chk("relock after held cfg", n, 4);
        trace(11, t0, t1);
        chk("ch0 div0 every cycle", 32'(t0), 32'h7FF);
        chk("ch1 phase clamp k=0,5,10", 32'(t1), 32'h421);

        cfg(0, 5, 0, w);
        tick();
        wait_lock(n);
        lk = 1'b1;
        t0 = '0;
        t1 = '0;
        for (int j = 0; j < 10; j++) begin
            t0[j] = en_out[0];
            t1[j] = en_out[1];
            lk &= locked;
            run = !(j >= 1 && j <= 3);
            tick();
        end
        run = 1'b1;
        chk("run gap moves ch0 to k=7", 32'(t0), 32'h080);
        chk("run gap ch1 k=0,8", 32'(t1), 32'h101);
        chk("locked through run gap", 32'(lk), 1);

        tick();
        #3 rst = 1'b1;
        #1;
        chk("async rst en_out", 32'(en_out), 0);
        chk("async rst locked", 32'(locked), 0);
        chk("async rst ready", 32'(cfg_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        wait_lock(n);
        chk("lock after reset release", n, 4);
        trace(6, t0, t1);
        chk("post-reset ch0 div2", 32'(t0), 32'h2A);
        chk("post-reset ch1 div2", 32'(t1), 32'h2A);

        chk("3ch instance ready", 32'(cfg_ready3), 1);
        cfg_ch3 = 2'd3;
        cfg_valid3 = 1'b1;
        tick();
        cfg_valid3 = 1'b0;
        lk = 1'b1;
        p3 = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            lk &= locked3 & cfg_ready3;
            p3 += int'(en_out3[0]);
        end
        chk("invalid ch keeps lock", 32'(lk), 1);
        chk("invalid ch keeps div2 strobes", p3, 4);

        for (int j = 0; j < 400; j++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch = 1'($urandom_range(0, 1));
            cfg_div = 8'($urandom_range(0, 7));
            cfg_phase = 8'($urandom_range(0, 8));
            run = ($urandom_range(0, 3) != 0);
            tick();
        end
        cfg_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
